// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                   input  dmem_rdata, dmem_ack);
   modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                   output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: passes ALU ops through, runs stalled req/ack handshakes for loads/stores
// and formats load data for MEM/WB; flags misaligned accesses and acknowledge timeouts.
module mem_access_stage #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ex_valid_i,
   input  logic                        ex_mem_read_i,
   input  logic                        ex_mem_write_i,
   input  logic [1:0]                  ex_size_i,
   input  logic                        ex_unsigned_i,
   input  logic                        ex_reg_write_i,
   input  logic                        ex_mem2reg_i,
   input  logic [31:0]                 ex_alu_i,
   input  logic [31:0]                 ex_store_i,
   input  logic [4:0]                  ex_write_reg_i,
   mem_access_stage_if.master          dmem,
   output logic                        stall_o,
   output logic                        wb_reg_write_o,
   output logic                        wb_mem2reg_o,
   output logic [31:0]                 wb_mem_o,
   output logic [31:0]                 wb_alu_o,
   output logic [4:0]                  wb_write_reg_o,
   output logic                        misalign_err_o,
   output logic                        bus_err_o
);
   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic        rw;
      logic        m2r;
      logic [4:0]  wreg;
      logic [31:0] alu;
      logic [3:0]  be;
      logic [31:0] wdata;
   } lat_t;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   lat_t           lat_q, lat_d;
   logic [31:0]    res_q, res_d;

   logic [1:0]     lane;
   logic [3:0]     be_c;
   logic [31:0]    wdata_c;
   logic           misal_c, access_c;
   logic [7:0]     ld_b;
   logic [15:0]    ld_h;
   logic [31:0]    ld_fmt;

   // request formatting from the EX/MEM fields
   always_comb begin
      lane = ex_alu_i[1:0];
      case (ex_size_i)
         2'b00:   begin be_c = 4'b0001 << lane;                   wdata_c = {4{ex_store_i[7:0]}};  end
         2'b01:   begin be_c = lane[1] ? 4'b1100 : 4'b0011;       wdata_c = {2{ex_store_i[15:0]}}; end
         default: begin be_c = 4'b1111;                           wdata_c = ex_store_i;            end
      endcase
      misal_c  = ((ex_size_i == 2'b01) & lane[0]) | (ex_size_i[1] & (lane != 2'b00));
      access_c = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
   end

   // load lane extraction from the latched address/size
   always_comb begin
      ld_b = dmem.dmem_rdata[{lat_q.alu[1:0], 3'b000} +: 8];
      ld_h = lat_q.alu[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      case (lat_q.size)
         2'b00:   ld_fmt = {{24{ld_b[7] & ~lat_q.uns}}, ld_b};
         2'b01:   ld_fmt = {{16{ld_h[15] & ~lat_q.uns}}, ld_h};
         default: ld_fmt = dmem.dmem_rdata;
      endcase
      if (lat_q.we) ld_fmt = '0;
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      lat_d          = lat_q;
      res_d          = res_q;
      dmem.dmem_req  = 1'b0;
      stall_o        = 1'b0;
      wb_reg_write_o = 1'b0;
      wb_mem2reg_o   = 1'b0;
      wb_mem_o       = '0;
      wb_alu_o       = '0;
      wb_write_reg_o = '0;
      misalign_err_o = 1'b0;
      bus_err_o      = 1'b0;
      // while reset is held every output, including the combinational ones, reads 0
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (!access_c) begin
                  wb_reg_write_o = ex_reg_write_i & ex_valid_i;
                  wb_mem2reg_o   = ex_mem2reg_i;
                  wb_alu_o       = ex_alu_i;
                  wb_write_reg_o = ex_write_reg_i;
               end else if (misal_c) begin
                  misalign_err_o = 1'b1;
               end else begin
                  stall_o = 1'b1;
                  lat_d   = '{we: ex_mem_write_i, size: ex_size_i, uns: ex_unsigned_i,
                              rw: ex_reg_write_i, m2r: ex_mem2reg_i, wreg: ex_write_reg_i,
                              alu: ex_alu_i, be: be_c, wdata: wdata_c};
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               dmem.dmem_req = 1'b1;
               stall_o       = 1'b1;
               if (dmem.dmem_ack) begin
                  res_d   = ld_fmt;
                  state_d = DONE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ABORT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DONE: begin
               wb_reg_write_o = lat_q.rw;
               wb_mem2reg_o   = lat_q.m2r;
               wb_mem_o       = res_q;
               wb_alu_o       = lat_q.alu;
               wb_write_reg_o = lat_q.wreg;
               state_d        = IDLE;
            end
            default: begin
               // unstalled bubble lets EX/MEM move past the timed-out instruction, discarding it
               bus_err_o = 1'b1;
               state_d   = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lat_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         res_q   <= res_d;
      end
   end

   assign dmem.dmem_we    = lat_q.we;
   assign dmem.dmem_addr  = {lat_q.alu[31:2], 2'b00};
   assign dmem.dmem_be    = lat_q.be;
   assign dmem.dmem_wdata = lat_q.wdata;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expected bus requests and retire
// records; independent monitors pop and compare them as the DUT presents them.
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0, ex_rd = 1'b0, ex_wr = 1'b0, ex_uns = 1'b0, ex_rw = 1'b0, ex_m2r = 1'b0;
   logic [1:0]  ex_size = 2'b00;
   logic [31:0] ex_alu = '0, ex_store = '0;
   logic [4:0]  ex_wreg = '0;
   logic        stall, wb_rw, wb_m2r, mis, berr;
   logic [31:0] wb_mem, wb_alu;
   logic [4:0]  wb_wreg;

   int          total = 0, bad = 0;
   int          ack_at = 0;
   logic [31:0] rd_val = '0;

   typedef struct packed {
      logic rw; logic m2r; logic [31:0] mem; logic [31:0] alu; logic [4:0] wreg; logic mis; logic berr;
   } wb_t;
   typedef struct packed {
      logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
   } rq_t;

   wb_t wbq[$];
   rq_t rqq[$];

   mem_access_stage_if dmem ();

   mem_access_stage #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ex_valid_i(ex_valid), .ex_mem_read_i(ex_rd), .ex_mem_write_i(ex_wr), .ex_size_i(ex_size),
      .ex_unsigned_i(ex_uns), .ex_reg_write_i(ex_rw), .ex_mem2reg_i(ex_m2r), .ex_alu_i(ex_alu),
      .ex_store_i(ex_store), .ex_write_reg_i(ex_wreg), .dmem(dmem.master),
      .stall_o(stall), .wb_reg_write_o(wb_rw), .wb_mem2reg_o(wb_m2r), .wb_mem_o(wb_mem),
      .wb_alu_o(wb_alu), .wb_write_reg_o(wb_wreg), .misalign_err_o(mis), .bus_err_o(berr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic wb_t mk_wb(input logic rw, m2r, input logic [31:0] mem, alu,
                                 input logic [4:0] wreg, input logic m, b);
      mk_wb = '{rw: rw, m2r: m2r, mem: mem, alu: alu, wreg: wreg, mis: m, berr: b};
   endfunction

   // memory model: acks on the ack_at-th request cycle (0 = never)
   initial begin
      int cnt;
      cnt = 0;
      dmem.dmem_ack   = 1'b0;
      dmem.dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (dmem.dmem_req) begin
            cnt++;
            dmem.dmem_ack   = (ack_at != 0) && (cnt == ack_at);
            dmem.dmem_rdata = rd_val;
         end else begin
            cnt           = 0;
            dmem.dmem_ack = 1'b0;
         end
      end
   end

   // monitor: new bus requests and retiring instructions
   initial begin
      logic req_prev;
      wb_t  ew;
      rq_t  er;
      req_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            req_prev = 1'b0;
         end else begin
            if (dmem.dmem_req && !req_prev) begin
               if (rqq.size() == 0) chk("unexpected_req", 80'd1, 80'd0);
               else begin
                  er = rqq.pop_front();
                  chk("req", {dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata}, er);
               end
            end
            req_prev = dmem.dmem_req;
            if (ex_valid && !stall) begin
               if (wbq.size() == 0) chk("unexpected_retire", 80'd1, 80'd0);
               else begin
                  ew = wbq.pop_front();
                  chk("retire", {wb_rw, wb_m2r, wb_mem, wb_alu, wb_wreg, mis, berr}, ew);
               end
            end
         end
      end
   end

   task automatic do_op(input string name, input logic rd, wr, input logic [1:0] sz,
                        input logic uns, rw, m2r, input logic [31:0] alu, st,
                        input logic [4:0] wreg, input int ack_n, input logic [31:0] rdv,
                        input int exp_stall, exp_req, input wb_t ewb,
                        input logic has_req, input rq_t erq);
      int  n_stall, n_req;
      bit  done;
      @(posedge clk); #1;
      ack_at = ack_n; rd_val = rdv;
      ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_size = sz; ex_uns = uns;
      ex_rw = rw; ex_m2r = m2r; ex_alu = alu; ex_store = st; ex_wreg = wreg;
      wbq.push_back(ewb);
      if (has_req) rqq.push_back(erq);
      n_stall = 0; n_req = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (dmem.dmem_req) n_req++;
         if (stall) n_stall++;
         else done = 1;
      end
      if (!done) chk({name, "_retire_timeout"}, 80'd0, 80'd1);
      chk({name, "_stall_cycles"}, 80'(n_stall), 80'(exp_stall));
      chk({name, "_req_cycles"}, 80'(n_req), 80'(exp_req));
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
   endtask

   initial begin
      // reset state with a load already presented
      ex_valid = 1'b1; ex_rd = 1'b1; ex_size = 2'b10; ex_alu = 32'h10; ex_rw = 1'b1;
      #12;
      chk("reset_outputs", {dmem.dmem_req, stall, wb_rw, wb_m2r, wb_mem, wb_alu, wb_wreg, mis, berr}, '0);
      ex_valid = 1'b0; ex_rd = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // invalid instruction: RegWrite suppressed, fields still pass through
      ex_alu = 32'h55; ex_rw = 1'b1;
      @(negedge clk);
      chk("invalid_rw", {wb_rw, wb_alu, stall}, {1'b0, 32'h55, 1'b0});

      do_op("pass", 0, 0, 2'b10, 0, 1, 0, 32'h1234, 0, 5'd5, 0, 0, 0, 0,
            mk_wb(1, 0, 0, 32'h1234, 5, 0, 0), 0, '0);
      do_op("lb", 1, 0, 2'b00, 0, 1, 1, 32'h103, 0, 5'd7, 2, 32'h80AABBCC, 3, 2,
            mk_wb(1, 1, 32'hFFFFFF80, 32'h103, 7, 0, 0), 1, '{0, 32'h100, 4'b1000, 32'h0});
      do_op("lbu", 1, 0, 2'b00, 1, 1, 1, 32'h103, 0, 5'd7, 2, 32'h80AABBCC, 3, 2,
            mk_wb(1, 1, 32'h00000080, 32'h103, 7, 0, 0), 1, '{0, 32'h100, 4'b1000, 32'h0});
      do_op("sh", 0, 1, 2'b01, 0, 0, 0, 32'h202, 32'h0000BEEF, 5'd9, 1, 32'hDEADBEEF, 2, 1,
            mk_wb(0, 0, 0, 32'h202, 9, 0, 0), 1, '{1, 32'h200, 4'b1100, 32'hBEEFBEEF});
      do_op("sb", 0, 1, 2'b00, 0, 0, 0, 32'h101, 32'h123456A5, 5'd0, 1, 32'h0, 2, 1,
            mk_wb(0, 0, 0, 32'h101, 0, 0, 0), 1, '{1, 32'h100, 4'b0010, 32'hA5A5A5A5});
      do_op("lh", 1, 0, 2'b01, 0, 1, 1, 32'h106, 0, 5'd4, 1, 32'h80017FFF, 2, 1,
            mk_wb(1, 1, 32'hFFFF8001, 32'h106, 4, 0, 0), 1, '{0, 32'h104, 4'b1100, 32'h0});
      do_op("lhu", 1, 0, 2'b01, 1, 1, 1, 32'h104, 0, 5'd6, 1, 32'hFFFF8123, 2, 1,
            mk_wb(1, 1, 32'h00008123, 32'h104, 6, 0, 0), 1, '{0, 32'h104, 4'b0011, 32'h0});
      do_op("lw_misalign", 1, 0, 2'b10, 0, 1, 1, 32'h101, 0, 5'd3, 1, 32'h0, 0, 0,
            mk_wb(0, 0, 0, 0, 0, 1, 0), 0, '0);
      do_op("lh_misalign", 1, 0, 2'b01, 0, 1, 1, 32'h103, 0, 5'd3, 1, 32'h0, 0, 0,
            mk_wb(0, 0, 0, 0, 0, 1, 0), 0, '0);
      do_op("timeout", 1, 0, 2'b10, 0, 1, 1, 32'h40, 0, 5'd8, 0, 32'h0, 5, 4,
            mk_wb(0, 0, 0, 0, 0, 0, 1), 1, '{0, 32'h40, 4'b1111, 32'h0});
      do_op("ack_at_limit", 1, 0, 2'b10, 0, 1, 1, 32'h44, 0, 5'd8, 4, 32'h11223344, 5, 4,
            mk_wb(1, 1, 32'h11223344, 32'h44, 8, 0, 0), 1, '{0, 32'h44, 4'b1111, 32'h0});

      // reset asserted mid-transaction
      @(posedge clk); #1;
      ack_at = 0;
      ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_size = 2'b10; ex_alu = 32'h80; ex_rw = 1'b1;
      rqq.push_back('{0, 32'h80, 4'b1111, 32'h0});
      @(negedge clk);
      @(negedge clk);
      chk("busy_before_reset", {dmem.dmem_req, stall}, {1'b1, 1'b1});
      #2 rst = 1'b1;
      #1;
      chk("reset_mid_busy", {dmem.dmem_req, stall, wb_rw, wb_m2r, wb_mem, wb_alu, wb_wreg}, '0);
      ex_valid = 1'b0; ex_rd = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      do_op("lw_after_reset", 1, 0, 2'b10, 0, 1, 1, 32'h10, 0, 5'd2, 1, 32'hCAFEF00D, 2, 1,
            mk_wb(1, 1, 32'hCAFEF00D, 32'h10, 2, 0, 0), 1, '{0, 32'h10, 4'b1111, 32'h0});

      repeat (2) @(posedge clk);
      chk("wb_queue_drained", 80'(wbq.size()), 80'd0);
      chk("req_queue_drained", 80'(rqq.size()), 80'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
